contadores_param: RTL



---
 rtl/contadores_param.sv | 121 ++++++++++++
 1 files changed

// File: rtl/contadores_param.sv
// Parametrised pop-event counter bank: one counter per FIFO channel with
// wrap/saturate overflow, sticky overflow flags and a request/valid read port.
module contadores_param #(
  parameter int unsigned NUM_CH      = 5,
  parameter int unsigned CNT_W       = 5,
  parameter int unsigned IDX_W       = 3,
  parameter int unsigned SAT_MODE    = 0,
  parameter int unsigned CLR_ON_READ = 1
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [NUM_CH-1:0] pop,
  input  logic              idle,
  input  logic              req,
  input  logic [IDX_W-1:0]  idx,
  output logic              valid,
  output logic [CNT_W-1:0]  data_out,
  output logic              ovf_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    ACTIVE = 2'd1,
    READY  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_rd_ok;

  logic [CNT_W-1:0]  r_cnt     [NUM_CH];
  logic [CNT_W-1:0]  w_cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0] r_ovf;
  logic [NUM_CH-1:0] w_ovf_nxt;
  logic [CNT_W-1:0]  w_sel_cnt;
  logic              w_sel_ovf;

  // State register
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and read acceptance; READY serves a request even while leaving
  always_comb begin
    w_state_nxt = r_state;
    w_rd_ok     = 1'b0;
    case (r_state)
      INIT:    w_state_nxt = ACTIVE;
      ACTIVE:  if (idle) w_state_nxt = READY;
      READY: begin
        if (!idle) w_state_nxt = ACTIVE;
        w_rd_ok = req && ({1'b0, idx} < (IDX_W+1)'(NUM_CH));
      end
      default: w_state_nxt = INIT;
    endcase
  end

  // Counter update and read mux; a clear-on-read still counts a same-edge pop
  always_comb begin
    w_sel_cnt = '0;
    w_sel_ovf = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      w_ovf_nxt[i] = r_ovf[i];
      if (idx == IDX_W'(i)) begin
        w_sel_cnt = r_cnt[i];
        w_sel_ovf = r_ovf[i];
      end
      if (r_state != INIT) begin
        if (w_rd_ok && (CLR_ON_READ != 0) && (idx == IDX_W'(i))) begin
          w_cnt_nxt[i] = CNT_W'(pop[i]);
          w_ovf_nxt[i] = 1'b0;
        end else if (pop[i]) begin
          if (r_cnt[i] == CNT_MAX) begin
            w_ovf_nxt[i] = 1'b1;
            w_cnt_nxt[i] = (SAT_MODE != 0) ? CNT_MAX : '0;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Counter and overflow flag registers
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= '0;
      end
      r_ovf <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      r_ovf <= w_ovf_nxt;
    end
  end

  // Read port registers; data holds its last result while valid is low
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      valid    <= 1'b0;
      data_out <= '0;
      ovf_out  <= 1'b0;
    end else begin
      valid <= w_rd_ok;
      if (w_rd_ok) begin
        data_out <= w_sel_cnt;
        ovf_out  <= w_sel_ovf;
      end
    end
  end

endmodule
